// File: rtl/axi_rd_arbiter_pkg.sv
// Shared AXI read-channel bundle types plus the read arbiter's state and owner encodings.
package axi_rd_arbiter_pkg;

    typedef struct packed {
        logic        arvalid;
        logic [31:0] araddr;
        logic [3:0]  arid;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic [3:0]  rid;
    } axi_r_s2m_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_AR_IFU  = 3'd1;
    localparam logic [2:0] ST_AR_LSU  = 3'd2;
    localparam logic [2:0] ST_R_IFU   = 3'd3;
    localparam logic [2:0] ST_R_LSU   = 3'd4;
    localparam logic [2:0] ST_R_DRAIN = 3'd5;

    typedef enum logic [2:0] {
        RD_IDLE    = ST_IDLE,
        RD_AR_IFU  = ST_AR_IFU,
        RD_AR_LSU  = ST_AR_LSU,
        RD_R_IFU   = ST_R_IFU,
        RD_R_LSU   = ST_R_LSU,
        RD_R_DRAIN = ST_R_DRAIN
    } rd_arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IFU  = 2'b01,
        OWN_LSU  = 2'b10
    } rd_owner_e;

endpackage

// File: rtl/axi_rd_arbiter_watchdog.sv
// Stall watchdog: counts busy cycles without an AR/R handshake and raises a sticky flag
// once the count reaches TIMEOUT_CYCLES.
module rd_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic busy,
    input  logic hs,
    output logic timeout
);

    localparam logic [TO_W-1:0] CNT_MAX = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;
    logic            timeout_q;

    always_comb begin
        cnt_d = cnt_q;
        if (!busy || hs) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_q | (cnt_d == CNT_MAX);
        end
    end

    assign timeout = timeout_q;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares the external AXI read port between IFU and LSU, one outstanding transaction at a time.
// Define AXI_RD_ARB_RR_EN for round-robin arbitration; default is fixed LSU priority.
//
// state      | meaning
// IDLE       | no transaction; sample both arvalids, pick winner for next cycle
// AR_IFU     | IFU address phase forwarded to memory
// AR_LSU     | LSU address phase forwarded to memory
// R_IFU      | IFU data beats forwarded until rlast
// R_LSU      | LSU data beats forwarded until rlast
// R_DRAIN    | killed IFU transaction; beats accepted and discarded until rlast
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       clock,
    input  logic       reset,
    input  axi_r_m2s_t ifu_r_m2s_i,
    output axi_r_s2m_t ifu_r_s2m_o,
    input  axi_r_m2s_t lsu_r_m2s_i,
    output axi_r_s2m_t lsu_r_s2m_o,
    output axi_r_m2s_t mem_r_m2s_o,
    input  axi_r_s2m_t mem_r_s2m_i,
    input  logic       ifu_kill_i,
    output logic [1:0] owner_o,
    output logic       timeout_o
);

    rd_arb_state_e state_q;
    rd_arb_state_e state_d;
    logic          kill_pend_q;
    logic          kill_seen;
    logic          ar_hs;
    logic          r_hs;
    logic          r_last_hs;
    logic          grant_lsu;

    assign kill_seen = kill_pend_q | ifu_kill_i;
    assign ar_hs     = mem_r_m2s_o.arvalid & mem_r_s2m_i.arready;
    assign r_hs      = mem_r_s2m_i.rvalid & mem_r_m2s_o.rready;
    assign r_last_hs = r_hs & mem_r_s2m_i.rlast;

`ifdef AXI_RD_ARB_RR_EN
    logic last_lsu_q;

    // On a tie the master that did not win last time takes the grant.
    assign grant_lsu = lsu_r_m2s_i.arvalid & (~ifu_r_m2s_i.arvalid | ~last_lsu_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_lsu_q <= 1'b1;
        end else if (state_q == RD_IDLE && (ifu_r_m2s_i.arvalid || lsu_r_m2s_i.arvalid)) begin
            last_lsu_q <= grant_lsu;
        end
    end
`else
    assign grant_lsu = lsu_r_m2s_i.arvalid;
`endif

    always_comb begin
        mem_r_m2s_o = '0;
        ifu_r_s2m_o = '0;
        lsu_r_s2m_o = '0;
        owner_o     = OWN_NONE;
        case (state_q)
            RD_AR_IFU: begin
                mem_r_m2s_o         = ifu_r_m2s_i;
                mem_r_m2s_o.rready  = 1'b0;
                // A flushed IFU must not see its request as accepted.
                ifu_r_s2m_o.arready = mem_r_s2m_i.arready & ~kill_seen;
                owner_o             = OWN_IFU;
            end
            RD_AR_LSU: begin
                mem_r_m2s_o         = lsu_r_m2s_i;
                mem_r_m2s_o.rready  = 1'b0;
                lsu_r_s2m_o.arready = mem_r_s2m_i.arready;
                owner_o             = OWN_LSU;
            end
            RD_R_IFU: begin
                mem_r_m2s_o.rready  = ifu_r_m2s_i.rready;
                ifu_r_s2m_o         = mem_r_s2m_i;
                ifu_r_s2m_o.arready = 1'b0;
                owner_o             = OWN_IFU;
            end
            RD_R_LSU: begin
                mem_r_m2s_o.rready  = lsu_r_m2s_i.rready;
                lsu_r_s2m_o         = mem_r_s2m_i;
                lsu_r_s2m_o.arready = 1'b0;
                owner_o             = OWN_LSU;
            end
            RD_R_DRAIN: begin
                mem_r_m2s_o.rready = 1'b1;
                owner_o            = OWN_IFU;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE: begin
                if (grant_lsu) begin
                    state_d = RD_AR_LSU;
                end else if (ifu_r_m2s_i.arvalid) begin
                    state_d = RD_AR_IFU;
                end
            end
            RD_AR_IFU: begin
                if (ar_hs) begin
                    state_d = kill_seen ? RD_R_DRAIN : RD_R_IFU;
                end
            end
            RD_AR_LSU: begin
                if (ar_hs) begin
                    state_d = RD_R_LSU;
                end
            end
            RD_R_IFU: begin
                // A last beat coinciding with a kill completes normally.
                if (r_last_hs) begin
                    state_d = RD_IDLE;
                end else if (ifu_kill_i) begin
                    state_d = RD_R_DRAIN;
                end
            end
            RD_R_LSU, RD_R_DRAIN: begin
                if (r_last_hs) begin
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= RD_IDLE;
            kill_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kill_pend_q <= (state_q == RD_AR_IFU) & ~ar_hs & kill_seen;
        end
    end

    rd_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .busy    (state_q != RD_IDLE),
        .hs      (ar_hs | r_hs),
        .timeout (timeout_o)
    );

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios followed by randomized transactions
// checked against a transaction-level arbitration/delivery model. Honors AXI_RD_ARB_RR_EN.
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    localparam int TIMEOUT_CYCLES = 1024;
    localparam int TXN_BOUND      = 300;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    axi_r_m2s_t ifu_m2s, lsu_m2s, mem_m2s;
    axi_r_s2m_t ifu_s2m, lsu_s2m, mem_s2m;
    logic       ifu_kill;
    logic [1:0] owner;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;
    bit pend_ifu = 1'b0;
    bit pend_lsu = 1'b0;
`ifdef AXI_RD_ARB_RR_EN
    bit last_lsu = 1'b1;
`endif

    always #5 clock = ~clock;

    axi_rd_arbiter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clock       (clock),
        .reset       (reset),
        .ifu_r_m2s_i (ifu_m2s),
        .ifu_r_s2m_o (ifu_s2m),
        .lsu_r_m2s_i (lsu_m2s),
        .lsu_r_s2m_o (lsu_s2m),
        .mem_r_m2s_o (mem_m2s),
        .mem_r_s2m_i (mem_s2m),
        .ifu_kill_i  (ifu_kill),
        .owner_o     (owner),
        .timeout_o   (timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic raise(input bit is_lsu, input int len, input logic [31:0] addr);
        if (is_lsu) begin
            lsu_m2s.arvalid = 1'b1; lsu_m2s.araddr = addr; lsu_m2s.arid = 4'($urandom);
            lsu_m2s.arlen = 8'(len); lsu_m2s.arsize = 3'd2; lsu_m2s.arburst = 2'b01;
            pend_lsu = 1'b1;
        end else begin
            ifu_m2s.arvalid = 1'b1; ifu_m2s.araddr = addr; ifu_m2s.arid = 4'($urandom);
            ifu_m2s.arlen = 8'(len); ifu_m2s.arsize = 3'd2; ifu_m2s.arburst = 2'b01;
            pend_ifu = 1'b1;
        end
    endtask

    // Reference arbitration rule applied to the set of pending masters.
    task automatic pick_winner(output bit w_lsu);
        if (pend_lsu && pend_ifu) begin
`ifdef AXI_RD_ARB_RR_EN
            w_lsu = !last_lsu;
`else
            w_lsu = 1'b1;
`endif
        end else begin
            w_lsu = pend_lsu;
        end
`ifdef AXI_RD_ARB_RR_EN
        last_lsu = w_lsu;
`endif
    endtask

    task automatic drive_rready(input bit w_lsu, input bit rand_rready);
        if (rand_rready) begin
            ifu_m2s.rready = 1'($urandom);
            lsu_m2s.rready = 1'($urandom);
        end else begin
            ifu_m2s.rready = !w_lsu;
            lsu_m2s.rready = w_lsu;
        end
    endtask

    task automatic check_r(input bit w_lsu, input bit drained);
        axi_r_s2m_t ws, ls;
        ws = w_lsu ? lsu_s2m : ifu_s2m;
        ls = w_lsu ? ifu_s2m : lsu_s2m;
        chk("r_owner", owner, w_lsu ? 2'b10 : 2'b01);
        chk("r_mem_arvalid", mem_m2s.arvalid, 1'b0);
        chk("r_mem_rready", mem_m2s.rready,
            drained ? 1'b1 : (w_lsu ? lsu_m2s.rready : ifu_m2s.rready));
        chk("r_loser_rvalid", ls.rvalid, 1'b0);
        chk("r_loser_arready", ls.arready, 1'b0);
        if (drained) begin
            chk("drain_ifu_rvalid", ifu_s2m.rvalid, 1'b0);
        end else begin
            chk("r_rvalid", ws.rvalid, mem_s2m.rvalid);
            if (mem_s2m.rvalid) begin
                chk("r_rdata", ws.rdata, mem_s2m.rdata);
                chk("r_rlast", ws.rlast, mem_s2m.rlast);
                chk("r_rid", ws.rid, mem_s2m.rid);
                chk("r_rresp", ws.rresp, mem_s2m.rresp);
            end
        end
    endtask

    // One full transaction starting in IDLE with requests already raised.
    task automatic run_txn(input int ar_delay, input int ar_kill_at, input int r_kill_after,
                           input int gap_max, input bit rand_rready);
        bit         w_lsu, killed, drained, hs;
        axi_r_m2s_t req;
        int         nbeats, done, got, exp_got, cyc, gap;
        #1;
        chk("idle_owner", owner, 2'b00);
        chk("idle_no_comb_grant", mem_m2s.arvalid, 1'b0);
        chk("idle_timeout", timeout, 1'b0);
        pick_winner(w_lsu);
        req    = w_lsu ? lsu_m2s : ifu_m2s;
        nbeats = int'(req.arlen) + 1;
        killed = 1'b0;
        tick();
        for (int d = 0; d <= ar_delay; d++) begin
            mem_s2m.arready = (d == ar_delay);
            ifu_kill        = !w_lsu && (d == ar_kill_at);
            killed          = killed | ifu_kill;
            #1;
            chk("ar_owner", owner, w_lsu ? 2'b10 : 2'b01);
            chk("ar_valid", mem_m2s.arvalid, 1'b1);
            chk("ar_addr", mem_m2s.araddr, req.araddr);
            chk("ar_len", mem_m2s.arlen, req.arlen);
            chk("ar_id", mem_m2s.arid, req.arid);
            chk("ar_winner_ready", w_lsu ? lsu_s2m.arready : ifu_s2m.arready,
                (d == ar_delay) && !killed);
            chk("ar_loser_ready", w_lsu ? ifu_s2m.arready : lsu_s2m.arready, 1'b0);
            chk("ar_no_rvalid", ifu_s2m.rvalid | lsu_s2m.rvalid, 1'b0);
            tick();
        end
        ifu_kill        = 1'b0;
        mem_s2m.arready = 1'b0;
        if (w_lsu) begin
            lsu_m2s.arvalid = 1'b0; pend_lsu = 1'b0;
        end else begin
            ifu_m2s.arvalid = 1'b0; pend_ifu = 1'b0;
        end
        exp_got = killed ? 0 : ((!w_lsu && r_kill_after >= 0) ? r_kill_after : nbeats);
        drained = killed;
        done = 0; got = 0; cyc = 0;
        while (done < nbeats && cyc < TXN_BOUND) begin
            gap = int'($urandom_range(gap_max, 0));
            if (!w_lsu && !drained && r_kill_after == done && gap == 0) gap = 1;
            for (int g = 0; g < gap; g++) begin
                drive_rready(w_lsu, rand_rready);
                mem_s2m.rvalid = 1'b0;
                ifu_kill = !w_lsu && !drained && (r_kill_after == done) && (g == 0);
                #1;
                check_r(w_lsu, drained);
                tick();
                if (ifu_kill) drained = 1'b1;
                ifu_kill = 1'b0;
                cyc++;
            end
            mem_s2m.rvalid = 1'b1;
            mem_s2m.rdata  = $urandom;
            mem_s2m.rresp  = 2'($urandom);
            mem_s2m.rlast  = (done == nbeats - 1);
            mem_s2m.rid    = req.arid;
            hs = 1'b0;
            while (!hs && cyc < TXN_BOUND) begin
                drive_rready(w_lsu, rand_rready);
                #1;
                check_r(w_lsu, drained);
                hs = drained || (w_lsu ? lsu_m2s.rready : ifu_m2s.rready);
                tick();
                cyc++;
            end
            if (hs) begin
                if (!drained) got++;
                done++;
            end
            mem_s2m.rvalid = 1'b0;
            mem_s2m.rlast  = 1'b0;
        end
        ifu_m2s.rready = 1'b0;
        lsu_m2s.rready = 1'b0;
        chk("txn_in_bound", cyc < TXN_BOUND, 1'b1);
        chk("beats_to_master", got, exp_got);
        #1;
        chk("post_txn_idle", owner, 2'b00);
    endtask

    task automatic drain_pending();
        for (int k = 0; k < 2; k++) begin
            if (pend_ifu || pend_lsu) run_txn(0, -1, -1, 0, 1'b0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ifu_m2s = '0; lsu_m2s = '0; mem_s2m = '0; ifu_kill = 1'b0;
        pend_ifu = 1'b0; pend_lsu = 1'b0;
`ifdef AXI_RD_ARB_RR_EN
        last_lsu = 1'b1;
`endif
    endtask

    initial begin
        int len, ar_delay, ar_kill_at, r_kill_after;

        // Reset held with both masters requesting.
        do_reset();
        raise(1'b1, 0, 32'h8000_0100);
        raise(1'b0, 0, 32'h3000_0040);
        tick();
        tick();
        #1;
        chk("rst_mem_arvalid", mem_m2s.arvalid, 1'b0);
        chk("rst_mem_rready", mem_m2s.rready, 1'b0);
        chk("rst_ifu_arready", ifu_s2m.arready, 1'b0);
        chk("rst_lsu_arready", lsu_s2m.arready, 1'b0);
        chk("rst_ifu_rvalid", ifu_s2m.rvalid, 1'b0);
        chk("rst_lsu_rvalid", lsu_s2m.rvalid, 1'b0);
        chk("rst_owner", owner, 2'b00);
        chk("rst_timeout", timeout, 1'b0);
        tick();
        reset = 1'b1;
        run_txn(1, -1, -1, 0, 1'b0);
        drain_pending();

        // IFU 4-beat burst, rready tied high.
        raise(1'b0, 3, 32'h3000_0000);
        run_txn(0, -1, -1, 0, 1'b0);

        // Kill after the first beat of a 4-beat IFU burst.
        raise(1'b0, 3, 32'h3000_0010);
        run_txn(0, -1, 1, 0, 1'b0);

        // Kill while the AR is stalled for 3 cycles.
        raise(1'b0, 3, 32'h3000_0020);
        run_txn(3, 0, -1, 1, 1'b0);

        // Both masters requesting continuously, single beats.
        for (int i = 0; i < 6; i++) begin
            if (!pend_ifu) raise(1'b0, 0, $urandom);
            if (!pend_lsu) raise(1'b1, 0, $urandom);
            run_txn(0, -1, -1, 0, 1'b0);
        end
        drain_pending();

        // Slave stalls after the AR handshake: watchdog fires, then reset mid-burst.
        raise(1'b1, 0, 32'h8000_0200);
        #1;
        chk("wd_idle_owner", owner, 2'b00);
        tick();
        mem_s2m.arready = 1'b1;
        #1;
        chk("wd_ar_valid", mem_m2s.arvalid, 1'b1);
        tick();
        mem_s2m.arready = 1'b0;
        lsu_m2s.arvalid = 1'b0;
        pend_lsu = 1'b0;
        repeat (TIMEOUT_CYCLES - 1) tick();
        #1;
        chk("wd_before_limit", timeout, 1'b0);
        tick();
        #1;
        chk("wd_at_limit", timeout, 1'b1);
        chk("wd_fsm_unaltered", owner, 2'b10);
        repeat (5) tick();
        #1;
        chk("wd_sticky", timeout, 1'b1);
        do_reset();
        #1;
        chk("wd_reset_clears", timeout, 1'b0);
        chk("reset_midburst_owner", owner, 2'b00);
        chk("reset_midburst_rready", mem_m2s.rready, 1'b0);
        tick();
        reset = 1'b1;

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            if (!pend_ifu && $urandom_range(1, 0) == 1) raise(1'b0, int'($urandom_range(3, 0)), $urandom);
            if (!pend_lsu && $urandom_range(1, 0) == 1) raise(1'b1, int'($urandom_range(3, 0)), $urandom);
            if (!pend_ifu && !pend_lsu) raise(1'($urandom), int'($urandom_range(3, 0)), $urandom);
            len          = 3;
            ar_delay     = int'($urandom_range(3, 0));
            ar_kill_at   = (ar_delay > 0 && $urandom_range(5, 0) == 0) ? int'($urandom_range(ar_delay - 1, 0)) : -1;
            r_kill_after = ($urandom_range(3, 0) == 0) ? int'($urandom_range(len, 0)) : -1;
            if (r_kill_after >= 0 && pend_ifu && r_kill_after > int'(ifu_m2s.arlen)) r_kill_after = int'(ifu_m2s.arlen);
            run_txn(ar_delay, ar_kill_at, r_kill_after, 2, 1'b1);
        end
        drain_pending();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: observed simulation still running expected finished");
        $fatal(1, "time limit");
    end

endmodule
